exc_irq_ctrl: RTL

- Parametrised, sequential exception/interrupt controller for the pipelined MIPS core; sits beside the ID-stage decoder.
- Latches multiple interrupt channels with per-channel masking and fixed priority.
- Decides in ID whether to divert to the interrupt vector or the illegal-instruction vector; captures EPC and cause, flushes IF/ID, and tracks kernel/handler state until eret.
- Replaces the single-wire irq/pctop test previously hard-coded in the decoder.

---
 rtl/exc_irq_ctrl_pkg.sv | 20 ++
 rtl/exc_irq_ctrl_if.sv | 37 +++
 rtl/exc_irq_ctrl_prio_enc.sv | 24 ++
 rtl/exc_irq_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/exc_irq_ctrl_pkg.sv
// Shared encodings for the exception/interrupt controller: PC-source selects,
// controller states and the cause-register flag position.
package exc_pkg;

  localparam logic [2:0] PCSRC_NONE = 3'b000;
  localparam logic [2:0] PCSRC_IRQ  = 3'b100;
  localparam logic [2:0] PCSRC_EXC  = 3'b101;
  localparam logic [2:0] PCSRC_ERET = 3'b110;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } state_t;

  // Exception flag sits in the MSB of the cause register; low bits hold the channel.
  function automatic int unsigned cause_exc_flag(input int unsigned cause_w);
    return cause_w - 1;
  endfunction

endpackage

// File: rtl/exc_irq_ctrl_if.sv
// Core-side bundle of the exception/interrupt controller: interrupt lines,
// mask write port, ID-stage inputs and the redirect/status outputs.
interface exc_irq_ctrl_if #(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CAUSE_W = 5
);
  logic [NUM_IRQ-1:0] irq_in;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               id_valid;
  logic [PC_W-1:0]    id_pc;
  logic               id_undef;
  logic               id_eret;
  logic               pctop;
  logic               stall;

  logic               exc_take;
  logic [2:0]         exc_pcsrc;
  logic               flush;
  logic               eret_take;
  logic [PC_W-1:0]    epc;
  logic [CAUSE_W-1:0] cause;
  logic [NUM_IRQ-1:0] irq_pending;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               in_handler;

  modport master (
    output irq_in, mask_we, mask_wdata, id_valid, id_pc, id_undef, id_eret, pctop, stall,
    input  exc_take, exc_pcsrc, flush, eret_take, epc, cause, irq_pending, irq_mask, in_handler
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, id_valid, id_pc, id_undef, id_eret, pctop, stall,
    output exc_take, exc_pcsrc, flush, eret_take, epc, cause, irq_pending, irq_mask, in_handler
  );
endinterface

// File: rtl/exc_irq_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc
  import exc_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/exc_irq_ctrl.sv
// ID-stage exception/interrupt controller: edge-latched masked IRQs, undefined-
// instruction trap, EPC/cause capture and eret. Optional nesting: NESTED_IRQ_EN.
module exc_irq_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CAUSE_W = 5
) (
  input logic          clk,
  input logic          reset,
  exc_irq_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned FLAG  = cause_exc_flag(CAUSE_W);
  localparam int unsigned LOW_W = CAUSE_W - 1;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q, pending_q, mask_q, clr, elig;
  logic [PC_W-1:0]    epc_q, epc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               win_v;
  logic [IDX_W-1:0]   win_idx;
  logic               go, take_irq, take_exc, eret_go, preempt, sh_full;
  logic [2:0]         pcsrc;
  logic [PC_W-1:0]    epc_sh;
  logic [CAUSE_W-1:0] cause_sh;

  assign elig = pending_q & ~mask_q;
  assign go   = bus.id_valid & ~bus.stall;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_enc (
    .req   (elig),
    .valid (win_v),
    .idx   (win_idx)
  );

`ifdef NESTED_IRQ_EN
  logic push, pop;
  logic               sh_full_q;
  logic [PC_W-1:0]    epc_sh_q;
  logic [CAUSE_W-1:0] cause_sh_q;

  assign push     = take_irq & (state_q == HANDLER);
  assign pop      = eret_go & sh_full_q;
  assign sh_full  = sh_full_q;
  assign epc_sh   = epc_sh_q;
  assign cause_sh = cause_sh_q;
  // Only a strictly higher-priority interrupt may interrupt an interrupt handler.
  assign preempt  = win_v & ~cause_q[FLAG] & ~sh_full_q &
                    (LOW_W'(win_idx) < cause_q[LOW_W-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_full_q  <= 1'b0;
      epc_sh_q   <= '0;
      cause_sh_q <= '0;
    end else if (push) begin
      sh_full_q  <= 1'b1;
      epc_sh_q   <= epc_q;
      cause_sh_q <= cause_q;
    end else if (pop) begin
      sh_full_q  <= 1'b0;
    end
  end
`else
  assign preempt  = 1'b0;
  assign sh_full  = 1'b0;
  assign epc_sh   = '0;
  assign cause_sh = '0;
`endif

  always_comb begin
    state_d  = state_q;
    take_irq = 1'b0;
    take_exc = 1'b0;
    eret_go  = 1'b0;
    pcsrc    = PCSRC_NONE;
    epc_d    = epc_q;
    cause_d  = cause_q;
    case (state_q)
      IDLE: begin
        if (go && !bus.pctop) begin
          if (bus.id_undef) begin
            take_exc    = 1'b1;
            pcsrc       = PCSRC_EXC;
            epc_d       = bus.id_pc + PC_W'(4);
            cause_d     = '0;
            cause_d[FLAG] = 1'b1;
            state_d     = HANDLER;
          end else if (win_v) begin
            take_irq = 1'b1;
            pcsrc    = PCSRC_IRQ;
            epc_d    = bus.id_pc;
            cause_d  = {1'b0, LOW_W'(win_idx)};
            state_d  = HANDLER;
          end
        end
      end
      HANDLER: begin
        if (go && preempt) begin
          take_irq = 1'b1;
          pcsrc    = PCSRC_IRQ;
          epc_d    = bus.id_pc;
          cause_d  = {1'b0, LOW_W'(win_idx)};
        end else if (go && bus.id_eret) begin
          eret_go = 1'b1;
          pcsrc   = PCSRC_ERET;
          // A nested return restores the outer context and stays in the handler.
          if (sh_full) begin
            epc_d   = epc_sh;
            cause_d = cause_sh;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      clr[i] = take_irq && (win_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '1;
      epc_q      <= '0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= bus.irq_in;
      // A fresh edge on a channel being taken this cycle must not be lost.
      pending_q  <= (pending_q & ~clr) | (bus.irq_in & ~irq_prev_q);
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
    end
  end

  assign bus.exc_take    = take_irq | take_exc;
  assign bus.eret_take   = eret_go;
  assign bus.flush       = take_irq | take_exc | eret_go;
  assign bus.exc_pcsrc   = pcsrc;
  assign bus.epc         = epc_q;
  assign bus.cause       = cause_q;
  assign bus.irq_pending = pending_q;
  assign bus.irq_mask    = mask_q;
  assign bus.in_handler  = (state_q == HANDLER);

endmodule
